// File: rtl/sqr_wav_meas_pkg.sv
// Shared types and defaults for the square wave generator / measurement pair.
// The unit width bounds both the generator controls and the measured results.
package sqr_wav_pkg;

    localparam int SQR_UNIT_NS = 100;
    localparam int SQR_CLK_NS  = 10;
    localparam int UNIT_W      = 4;
    localparam int UNIT_MAX    = (1 << UNIT_W) - 1;

    typedef logic [UNIT_W-1:0] unit_t;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        STUCK = 2'd3
    } meas_state_t;

    // One rounded phase: value in units plus a flag for clamp/saturation.
    typedef struct packed {
        unit_t val;
        logic  err;
    } phase_res_t;

endpackage

// File: rtl/sqr_wav_meas_if.sv
// Measurement bus: the wave under test going in, one (high, low) pair coming out.
interface sqr_wav_meas_if;
    import sqr_wav_pkg::*;

    logic  sqr_in;
    unit_t high_m;
    unit_t low_n;
    logic  meas_valid;
    logic  err;
    logic  stuck;

    modport master (
        output sqr_in,
        input  high_m, low_n, meas_valid, err, stuck
    );

    modport slave (
        input  sqr_in,
        output high_m, low_n, meas_valid, err, stuck
    );

endinterface

// File: rtl/sqr_wav_meas_sync_edge_det.sv
// Multi-stage synchroniser for an asynchronous level, with one-cycle rise/fall
// strobes derived from the synchronised level and its previous value.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic s_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] chain_q;
    logic              s_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q[0] <= 1'b0;
        end else begin
            chain_q[0] <= d_i;
        end
    end

    generate
        for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    chain_q[gi] <= 1'b0;
                end else begin
                    chain_q[gi] <= chain_q[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_prev_q <= 1'b0;
        end else begin
            s_prev_q <= chain_q[STAGES-1];
        end
    end

    assign s_o    = chain_q[STAGES-1];
    assign rise_o = chain_q[STAGES-1] & ~s_prev_q;
    assign fall_o = ~chain_q[STAGES-1] & s_prev_q;

endmodule

// File: rtl/sqr_wav_meas.sv
// Square wave measurement: times each synchronised phase, rounds it to whole
// units and publishes one (high, low) pair per period, or a constant-level report.
module sqr_wav_meas
    import sqr_wav_pkg::*;
#(
    parameter int CLK_NS    = SQR_CLK_NS,
    parameter int UNIT_NS   = SQR_UNIT_NS,
    parameter int TIMEOUT_U = 20
) (
    input  logic           clk,
    input  logic           reset,
    sqr_wav_meas_if.slave  bus
);

    localparam int TPU     = UNIT_NS / CLK_NS;
    localparam int PRE_W   = (TPU > 1) ? $clog2(TPU) : 1;
    localparam int CNT_W   = $clog2(TIMEOUT_U + 1);
    // Counter holds L-1 at the closing edge, so round-half-up becomes pre >= this.
    localparam int RND_PRE = TPU - TPU / 2 - 1;

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TPU - 1);
    localparam logic [PRE_W-1:0] PRE_RND   = PRE_W'(RND_PRE);
    localparam logic [CNT_W-1:0] UNIT_TO   = CNT_W'(TIMEOUT_U - 1);
    localparam logic [CNT_W-1:0] UNIT_SAT  = CNT_W'(TIMEOUT_U);
    localparam logic [CNT_W:0]   RND_MAX   = (CNT_W + 1)'(UNIT_MAX);
    localparam unit_t            UNIT_FULL = unit_t'(UNIT_MAX);

    logic s, rise, fall, edge_det;

    sync_edge_det #(.STAGES(2)) u_sync (
        .clk    (clk),
        .rst    (reset),
        .d_i    (bus.sqr_in),
        .s_o    (s),
        .rise_o (rise),
        .fall_o (fall)
    );

    assign edge_det = rise | fall;

    // ---------------- phase timer ----------------
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] unit_q, unit_d;
    logic             timeout;

    always_comb begin
        pre_d  = pre_q;
        unit_d = unit_q;
        if (edge_det) begin
            pre_d  = '0;
            unit_d = '0;
        end else if (unit_q != UNIT_SAT) begin
            if (pre_q == PRE_LAST) begin
                pre_d  = '0;
                unit_d = unit_q + 1'b1;
            end else begin
                pre_d  = pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q  <= '0;
            unit_q <= '0;
        end else begin
            pre_q  <= pre_d;
            unit_q <= unit_d;
        end
    end

    // Fires in the cycle where a closing edge would have measured exactly the timeout length.
    assign timeout = !edge_det && (unit_q == UNIT_TO) && (pre_q == PRE_LAST);

    // ---------------- rounding ----------------
    logic [CNT_W:0] rnd_units;
    phase_res_t     phase;

    always_comb begin
        rnd_units = {1'b0, unit_q} + {{CNT_W{1'b0}}, (pre_q >= PRE_RND)};
        phase.val = unit_t'(rnd_units);
        phase.err = 1'b0;
        if (rnd_units == '0) begin
            phase.val = unit_t'(1);
            phase.err = 1'b1;
        end else if (rnd_units > RND_MAX) begin
            phase.val = UNIT_FULL;
            phase.err = 1'b1;
        end
    end

    // ---------------- FSM ----------------
    meas_state_t state_q, state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC: begin
                if (rise)         state_d = HIGH;
                else if (timeout) state_d = STUCK;
            end
            HIGH: begin
                if (fall)         state_d = LOW;
                else if (timeout) state_d = STUCK;
            end
            LOW: begin
                if (rise)         state_d = HIGH;
                else if (timeout) state_d = STUCK;
            end
            STUCK: begin
                if (rise)         state_d = HIGH;
                else if (fall)    state_d = SYNC;
            end
            default: state_d = SYNC;
        endcase
    end

    // ---------------- outputs ----------------
    phase_res_t hlat_q, hlat_d;
    unit_t      high_q, high_d, low_q, low_d;
    logic       valid_q, valid_d, err_q, err_d, stuck_q, stuck_d;

    always_comb begin
        hlat_d  = hlat_q;
        high_d  = high_q;
        low_d   = low_q;
        err_d   = err_q;
        stuck_d = stuck_q;
        valid_d = 1'b0;
        if (state_q == HIGH && fall) begin
            hlat_d = phase;
        end
        if (state_q == LOW && rise) begin
            valid_d = 1'b1;
            high_d  = hlat_q.val;
            low_d   = phase.val;
            err_d   = hlat_q.err | phase.err;
            stuck_d = 1'b0;
        end else if (state_q != STUCK && timeout) begin
            valid_d = 1'b1;
            high_d  = s ? UNIT_FULL : '0;
            low_d   = s ? '0 : UNIT_FULL;
            err_d   = 1'b0;
            stuck_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hlat_q  <= '0;
            high_q  <= '0;
            low_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            stuck_q <= 1'b0;
        end else begin
            hlat_q  <= hlat_d;
            high_q  <= high_d;
            low_q   <= low_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            stuck_q <= stuck_d;
        end
    end

    assign bus.high_m     = high_q;
    assign bus.low_n      = low_q;
    assign bus.meas_valid = valid_q;
    assign bus.err        = err_q;
    assign bus.stuck      = stuck_q;

endmodule

// File: tb/tb_sqr_wav_meas.sv
// Directed bench for sqr_wav_meas: drives phase sequences and checks published pairs.
module tb_sqr_wav_meas;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   failures;

    int   pulse_cnt;
    int   dbl_cnt;
    int   last_cyc;
    int   last_h, last_l, last_e, last_s;
    logic prev_valid;

    sqr_wav_meas_if bus();

    sqr_wav_meas #(.CLK_NS(10), .UNIT_NS(100), .TIMEOUT_U(20)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Publish monitor, sampled on the falling edge.
    always @(negedge clk) begin
        prev_valid <= bus.meas_valid;
        if (bus.meas_valid === 1'b1) begin
            pulse_cnt <= pulse_cnt + 1;
            last_cyc  <= cyc;
            last_h    <= int'(bus.high_m);
            last_l    <= int'(bus.low_n);
            last_e    <= int'(bus.err);
            last_s    <= int'(bus.stuck);
            if (prev_valid === 1'b1) dbl_cnt <= dbl_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic lvl(input logic v, input int n);
        bus.sqr_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_pair(input string tag, input int h, input int l, input int e, input int s);
        $display("pair %s: high_m=%0d low_n=%0d err=%0d stuck=%0d", tag, last_h, last_l, last_e, last_s);
        chk({tag, ".high"},  32'(last_h), 32'(h));
        chk({tag, ".low"},   32'(last_l), 32'(l));
        chk({tag, ".err"},   32'(last_e), 32'(e));
        chk({tag, ".stuck"}, 32'(last_s), 32'(s));
    endtask

    int t1, t2, tr, n0;

    initial begin
        checks = 0; failures = 0; cyc = 0;
        pulse_cnt = 0; dbl_cnt = 0; last_cyc = 0;
        last_h = -1; last_l = -1; last_e = -1; last_s = -1;
        prev_valid = 1'b0;
        reset = 1'b1;
        bus.sqr_in = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst.high",  32'(bus.high_m), 32'd0);
        chk("rst.low",   32'(bus.low_n), 32'd0);
        chk("rst.valid", 32'(bus.meas_valid), 32'd0);
        chk("rst.err",   32'(bus.err), 32'd0);
        chk("rst.stuck", 32'(bus.stuck), 32'd0);
        reset = 1'b0;

        // Stuck low from reset: nothing early, then 0/15 stuck
        lvl(1'b0, 190);
        chk("stlow.none", 32'(pulse_cnt), 32'd0);
        lvl(1'b0, 20);
        chk("stlow.cnt", 32'(pulse_cnt), 32'd1);
        chk_pair("stlow", 0, 15, 0, 1);

        // 30/50 wave: first pair at the closing rise + 3, then every 80 cycles
        lvl(1'b1, 30);
        lvl(1'b0, 50);
        t1 = cyc;
        lvl(1'b1, 30);
        chk("w3050.cnt", 32'(pulse_cnt), 32'd2);
        chk("w3050.cyc", 32'(last_cyc), 32'(t1 + 3));
        chk_pair("w3050", 3, 5, 0, 0);
        lvl(1'b0, 50);
        t2 = cyc;
        lvl(1'b1, 5);
        chk("w3050b.cnt", 32'(pulse_cnt), 32'd3);
        chk("w3050b.cyc", 32'(last_cyc), 32'(t1 + 83));

        // 34/35: round half up
        lvl(1'b1, 29);
        lvl(1'b0, 35);
        lvl(1'b1, 3);
        lvl(1'b0, 50);
        chk_pair("w3435", 3, 4, 0, 0);

        // 3/50 clamps high to 1, then 170/20 saturates high to 15
        lvl(1'b1, 170);
        chk_pair("w0350", 1, 5, 1, 0);
        lvl(1'b0, 20);
        lvl(1'b1, 30);
        chk_pair("w17020", 15, 2, 1, 0);
        lvl(1'b0, 50);
        tr = cyc;
        lvl(1'b1, 5);
        chk_pair("errclr", 3, 5, 0, 0);

        // Stuck high: report at rise + TIMEOUT + 3
        n0 = pulse_cnt;
        lvl(1'b1, 205);
        chk("sthigh.cnt", 32'(pulse_cnt), 32'(n0 + 1));
        chk("sthigh.cyc", 32'(last_cyc), 32'(tr + 203));
        chk_pair("sthigh", 15, 0, 0, 1);

        // Falling edge out of STUCK resyncs: no pair until a full period
        n0 = pulse_cnt;
        lvl(1'b0, 30);
        chk("resync.none1", 32'(pulse_cnt), 32'(n0));
        lvl(1'b1, 30);
        lvl(1'b0, 50);
        chk("resync.none2", 32'(pulse_cnt), 32'(n0));
        lvl(1'b1, 5);
        chk("resync.cnt", 32'(pulse_cnt), 32'(n0 + 1));
        chk_pair("resync", 3, 5, 0, 0);

        // Reset during LOW clears outputs immediately and restarts from SYNC
        lvl(1'b1, 25);
        lvl(1'b0, 20);
        reset = 1'b1;
        #1;
        chk("midrst.high",  32'(bus.high_m), 32'd0);
        chk("midrst.low",   32'(bus.low_n), 32'd0);
        chk("midrst.valid", 32'(bus.meas_valid), 32'd0);
        chk("midrst.err",   32'(bus.err), 32'd0);
        chk("midrst.stuck", 32'(bus.stuck), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        n0 = pulse_cnt;
        lvl(1'b0, 30);
        lvl(1'b1, 30);
        lvl(1'b0, 50);
        chk("midrst.none", 32'(pulse_cnt), 32'(n0));
        lvl(1'b1, 5);
        chk("midrst.cnt", 32'(pulse_cnt), 32'(n0 + 1));
        chk_pair("midrst", 3, 5, 0, 0);

        chk("valid.onecycle", 32'(dbl_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
